eth_ipv4_deparser: RTL and testbench

Transmit-side counterpart of the Ethernet/IPv4 parser. It accepts one eth_header_t plus one ipv4_header_t per frame over a valid/ready handshake, and a payload over a 64-bit AXI-Stream slave. It emits a byte-packed, big-endian AXI-Stream frame: 14 B Ethernet header, then 20 B IPv4 header, then the payload realigned by 2 bytes. It sits before the MAC TX path; min-frame padding and FCS are added downstream.

---
 rtl/axis_pkg.sv | 34 +++
 rtl/parser_pkg.sv | 56 +++++
 rtl/ipv4_csum_gen.sv | 49 ++++
 rtl/eth_ipv4_deparser.sv | 212 +++++++++++++++++++++
 tb/tb_eth_ipv4_deparser.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Helpers for 64-bit byte-packed AXI-Stream keep vectors.
//               Keep bit 7 corresponds to byte 0 (tdata[63:56]); keeps are
//               contiguous from the MSB.
//                 keep_from_count(n) - keep with the top n bits set (n<=8)
//                 count_from_keep(k) - number of set bits in k
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

    function automatic logic [7:0] keep_from_count(input logic [3:0] n);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                k[7-i] = 1'b1;
            end
        end
        return k;
    endfunction

    function automatic logic [3:0] count_from_keep(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, keep[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parser_pkg
// Description : Shared Ethernet/IPv4 header types and constants used by the
//               receive-side parser and the transmit-side deparser.
//               Contents:
//                 eth_header_t     - dst_mac, src_mac, ethertype (112 bits)
//                 ipv4_header_t    - 20-byte option-less IPv4 header, fields
//                                    in wire order, so the packed vector is
//                                    the header exactly as sent (160 bits)
//                 deparser_state_t - transmit deparser state encoding
// Revision    : 1.1 - deparser constants and state encoding added
// ============================================================================
package parser_pkg;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } eth_header_t;

    // Field order matches the wire order. Slicing this struct into 16-bit
    // chunks therefore gives the ten checksum words directly.
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] total_length;
        logic [15:0] identification;
        logic [2:0]  flags;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_header_t;

    localparam int          ETH_HDR_BYTES      = 14;
    localparam int          IPV4_MIN_HDR_BYTES = 20;
    localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
    localparam logic [3:0]  IPV4_VERSION       = 4'd4;
    localparam logic [3:0]  IPV4_MIN_IHL       = 4'd5;

    typedef enum logic [2:0] {
        DP_IDLE  = 3'd0,
        DP_H0    = 3'd1,
        DP_H1    = 3'd2,
        DP_H2    = 3'd3,
        DP_H3    = 3'd4,
        DP_PAY   = 3'd5,
        DP_FLUSH = 3'd6
    } deparser_state_t;

endpackage
`default_nettype wire

// File: rtl/ipv4_csum_gen.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_csum_gen
// Description : Combinational IPv4 header checksum. Sums the ten 16-bit
//               header words with end-around carry and returns the one's
//               complement of the sum.
//               Ports:
//                 i_hdr       - option-less IPv4 header
//                 i_incl_csum - 0: checksum field is treated as zero
//                               (generation); 1: the field is included, so
//                               a valid received header yields 16'h0000
//                               (checking)
//                 o_csum      - one's complement of the folded sum
// Revision    : 1.0 - initial release
// ============================================================================
module ipv4_csum_gen
    import parser_pkg::*;
(
    input  ipv4_header_t i_hdr,
    input  logic         i_incl_csum,
    output logic [15:0]  o_csum
);

    ipv4_header_t w_hdr;
    logic [159:0] w_bits;
    logic [19:0]  w_sum;
    logic [16:0]  w_fold1;
    logic [15:0]  w_fold2;

    always_comb begin
        w_hdr = i_hdr;
        if (!i_incl_csum) begin
            w_hdr.checksum = '0;
        end
        w_bits = w_hdr;
        // Ten words of at most 16'hFFFF fit comfortably in 20 bits.
        w_sum = '0;
        for (int i = 0; i < 10; i++) begin
            w_sum = w_sum + {4'b0000, w_bits[159-16*i -: 16]};
        end
        // Two folds are enough: after the first the value is at most
        // 17'h1000E, whose own carry cannot ripple out again.
        w_fold1 = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
        w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};
        o_csum  = ~w_fold2;
    end

endmodule
`default_nettype wire

// File: rtl/eth_ipv4_deparser.sv
`default_nettype none
// ============================================================================
// Module      : eth_ipv4_deparser
// Description : Transmit-side Ethernet/IPv4 deparser. Accepts one Ethernet
//               header plus one IPv4 header per frame, then a payload stream,
//               and emits a big-endian byte-packed frame: 14 B Ethernet
//               header, 20 B IPv4 header, payload shifted by 2 bytes.
//               Ports:
//                 aclk, areset            - clock, sync active-high reset
//                 eth_hdr, ipv4_hdr       - header pair
//                 hdr_valid / hdr_ready   - header pair handshake
//                 hdr_err                 - pulse: version!=4 or ihl!=5
//                 s_axis_*                - 64-bit payload input
//                 m_axis_*                - 64-bit frame output (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_ipv4_deparser
    import parser_pkg::*;
    import axis_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter bit CSUM_GEN = 1'b1
)
(
    input  logic                  aclk,
    input  logic                  areset,
    input  eth_header_t           eth_hdr,
    input  ipv4_header_t          ipv4_hdr,
    input  logic                  hdr_valid,
    output logic                  hdr_ready,
    output logic                  hdr_err,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    if (DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "eth_ipv4_deparser: only DATA_W=64 is supported");
    end

    deparser_state_t r_state;
    eth_header_t     r_eth;
    ipv4_header_t    r_ip;
    logic [15:0]     r_res;
    logic [7:0]      r_flush_keep;
    logic            r_hdr_err;
    logic [63:0]     r_tdata;
    logic [7:0]      r_tkeep;
    logic            r_tvalid;
    logic            r_tlast;

    logic            w_adv;
    logic [15:0]     w_csum_calc;
    ipv4_header_t    w_ip_latch;
    logic [3:0]      w_in_cnt;
    logic            w_hdr_bad;

    ipv4_csum_gen u_csum (
        .i_hdr       (ipv4_hdr),
        .i_incl_csum (1'b0),
        .o_csum      (w_csum_calc)
    );

    // The latched header carries the checksum that will be sent, so H3 is
    // built from one source regardless of CSUM_GEN.
    always_comb begin
        w_ip_latch = ipv4_hdr;
        if (CSUM_GEN) begin
            w_ip_latch.checksum = w_csum_calc;
        end
    end

    assign w_adv     = !r_tvalid || m_axis_tready;
    assign w_in_cnt  = count_from_keep(s_axis_tkeep);
    assign w_hdr_bad = (ipv4_hdr.version != IPV4_VERSION) ||
                       (ipv4_hdr.ihl != IPV4_MIN_IHL);

    // Gated by areset so nothing is offered or accepted in the reset cycle.
    assign hdr_ready     = (r_state == DP_IDLE) && !areset;
    assign s_axis_tready = (r_state == DP_PAY) && w_adv && !areset;

    assign hdr_err       = r_hdr_err;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= DP_IDLE;
            r_eth        <= '0;
            r_ip         <= '0;
            r_res        <= '0;
            r_flush_keep <= '0;
            r_hdr_err    <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
        end else begin
            r_hdr_err <= 1'b0;
            // The output word is consumed unless a load below refills it.
            if (w_adv) begin
                r_tvalid <= 1'b0;
            end
            case (r_state)
                DP_IDLE: begin
                    if (hdr_valid) begin
                        r_eth     <= eth_hdr;
                        r_ip      <= w_ip_latch;
                        r_hdr_err <= w_hdr_bad;
                        // H0 goes out straight from the inputs so it is
                        // visible in the cycle after acceptance.
                        if (w_adv) begin
                            r_tdata  <= {eth_hdr.dst_mac, eth_hdr.src_mac[47:32]};
                            r_tkeep  <= 8'hFF;
                            r_tlast  <= 1'b0;
                            r_tvalid <= 1'b1;
                            r_state  <= DP_H1;
                        end else begin
                            r_state  <= DP_H0;
                        end
                    end
                end
                DP_H0: begin
                    if (w_adv) begin
                        r_tdata  <= {r_eth.dst_mac, r_eth.src_mac[47:32]};
                        r_tkeep  <= 8'hFF;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= DP_H1;
                    end
                end
                DP_H1: begin
                    if (w_adv) begin
                        r_tdata  <= {r_eth.src_mac[31:0], r_eth.ethertype,
                                     r_ip.version, r_ip.ihl, r_ip.tos};
                        r_tkeep  <= 8'hFF;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= DP_H2;
                    end
                end
                DP_H2: begin
                    if (w_adv) begin
                        r_tdata  <= {r_ip.total_length, r_ip.identification,
                                     r_ip.flags, r_ip.frag_offset,
                                     r_ip.ttl, r_ip.protocol};
                        r_tkeep  <= 8'hFF;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= DP_H3;
                    end
                end
                DP_H3: begin
                    if (w_adv) begin
                        r_tdata  <= {r_ip.checksum, r_ip.src_ip, r_ip.dst_ip[31:16]};
                        r_tkeep  <= 8'hFF;
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        // The low half of dst_ip leads the first payload word.
                        r_res    <= r_ip.dst_ip[15:0];
                        r_state  <= DP_PAY;
                    end
                end
                DP_PAY: begin
                    if (w_adv && s_axis_tvalid) begin
                        r_tdata  <= {r_res, s_axis_tdata[63:16]};
                        r_res    <= s_axis_tdata[15:0];
                        r_tvalid <= 1'b1;
                        if (s_axis_tlast && (w_in_cnt <= 4'd6)) begin
                            r_tkeep <= keep_from_count(w_in_cnt + 4'd2);
                            r_tlast <= 1'b1;
                            r_state <= DP_IDLE;
                        end else if (s_axis_tlast) begin
                            // 7 or 8 bytes: the last 1-2 bytes spill into
                            // one extra word held in r_res.
                            r_tkeep      <= 8'hFF;
                            r_tlast      <= 1'b0;
                            r_flush_keep <= keep_from_count(w_in_cnt - 4'd6);
                            r_state      <= DP_FLUSH;
                        end else begin
                            r_tkeep <= 8'hFF;
                            r_tlast <= 1'b0;
                        end
                    end
                end
                DP_FLUSH: begin
                    if (w_adv) begin
                        r_tdata  <= {r_res, 48'h0};
                        r_tkeep  <= r_flush_keep;
                        r_tlast  <= 1'b1;
                        r_tvalid <= 1'b1;
                        r_state  <= DP_IDLE;
                    end
                end
                default: begin
                    r_state <= DP_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_ipv4_deparser.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_ipv4_deparser
// Description : Self-checking bench for eth_ipv4_deparser. Two instances
//               share all inputs: index 0 generates the checksum, index 1
//               passes the input checksum through. Each frame is expanded
//               into its expected byte sequence, packed into 8-byte words
//               and queued per instance; a monitor pops and compares every
//               transferred output word and checks stability under stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_ipv4_deparser;
    import parser_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        eth_header_t  eth;
        ipv4_header_t ip;
        int           plen;
        logic [7:0]   pbase;
        logic [15:0]  exp_csum;
        logic         exp_err;
    } vec_t;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    eth_header_t  eth_hdr;
    ipv4_header_t ipv4_hdr;
    logic         hdr_valid = 1'b0;
    logic [63:0]  s_tdata = '0;
    logic [7:0]   s_tkeep = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         m_tready = 1'b1;

    logic         hdr_ready [2];
    logic         hdr_err   [2];
    logic         s_tready  [2];
    logic [63:0]  m_tdata   [2];
    logic [7:0]   m_tkeep   [2];
    logic         m_tvalid  [2];
    logic         m_tlast   [2];

    beat_t        q [2][$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           rnd_mode = 1'b0;
    vec_t         vecs [7];

    always #5 aclk = ~aclk;

    eth_ipv4_deparser #(.DATA_W(64), .CSUM_GEN(1'b1)) u_dut0 (
        .aclk(aclk), .areset(areset), .eth_hdr(eth_hdr), .ipv4_hdr(ipv4_hdr),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready[0]), .hdr_err(hdr_err[0]),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tready(m_tready)
    );

    eth_ipv4_deparser #(.DATA_W(64), .CSUM_GEN(1'b0)) u_dut1 (
        .aclk(aclk), .areset(areset), .eth_hdr(eth_hdr), .ipv4_hdr(ipv4_hdr),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready[1]), .hdr_err(hdr_err[1]),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tready(m_tready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %s, expected none", name, what);
    endtask

    function automatic logic [7:0] pay_byte(input vec_t v, input int j);
        return v.pbase + 8'(j);
    endfunction

    // Expected frame: header bytes in wire order, then payload, packed 8/word.
    task automatic build_expect(input vec_t v);
        logic [7:0]   bytes [$];
        logic [111:0] eb;
        logic [159:0] ib;
        ipv4_header_t ipx;
        beat_t        b;
        for (int d = 0; d < 2; d++) begin
            bytes.delete();
            eb = v.eth;
            for (int j = 0; j < 14; j++) bytes.push_back(eb[111-8*j -: 8]);
            ipx = v.ip;
            if (d == 0) ipx.checksum = v.exp_csum;
            ib = ipx;
            for (int j = 0; j < 20; j++) bytes.push_back(ib[159-8*j -: 8]);
            for (int j = 0; j < v.plen; j++) bytes.push_back(pay_byte(v, j));
            for (int w = 0; w * 8 < bytes.size(); w++) begin
                b.data = '0;
                b.keep = '0;
                for (int k = 0; k < 8; k++) begin
                    if (w * 8 + k < bytes.size()) begin
                        b.data[63-8*k -: 8] = bytes[w*8+k];
                        b.keep[7-k] = 1'b1;
                    end
                end
                b.last = ((w + 1) * 8 >= bytes.size());
                q[d].push_back(b);
            end
        end
    endtask

    task automatic make_beat(input vec_t v, input int bi);
        s_tdata = '0;
        s_tkeep = '0;
        for (int k = 0; k < 8; k++) begin
            if (bi * 8 + k < v.plen) begin
                s_tdata[63-8*k -: 8] = pay_byte(v, bi * 8 + k);
                s_tkeep[7-k] = 1'b1;
            end
        end
        s_tlast  = ((bi + 1) * 8 >= v.plen);
        s_tvalid = 1'b1;
    endtask

    task automatic wait_s_accept(output bit ok);
        int t = 0;
        ok = 1'b1;
        while (1) begin
            @(negedge aclk);
            if (s_tready[0]) break;
            if (++t > 500) begin
                fail("s_axis_timeout", "no tready");
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_header(input vec_t v);
        int t = 0;
        @(posedge aclk); #1;
        eth_hdr   = v.eth;
        ipv4_hdr  = v.ip;
        hdr_valid = 1'b1;
        while (1) begin
            @(negedge aclk);
            if (hdr_ready[0]) break;
            if (++t > 500) begin
                fail("hdr_timeout", "no hdr_ready");
                hdr_valid = 1'b0;
                return;
            end
        end
        @(posedge aclk); #1;
        hdr_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("hdr_err_pulse%0d", d), 64'(hdr_err[d]), 64'(v.exp_err));
            if (!rnd_mode) chk($sformatf("h0_latency%0d", d), 64'(m_tvalid[d]), 64'd1);
        end
        @(posedge aclk); #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("hdr_err_clear%0d", d), 64'(hdr_err[d]), 64'd0);
    endtask

    task automatic send_payload(input vec_t v);
        bit ok;
        for (int bi = 0; bi * 8 < v.plen; bi++) begin
            make_beat(v, bi);
            wait_s_accept(ok);
            @(posedge aclk); #1;
            if (!ok) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        build_expect(v);
        send_header(v);
        send_payload(v);
    endtask

    task automatic drain();
        int t = 0;
        while (q[0].size() != 0 || q[1].size() != 0) begin
            @(negedge aclk);
            if (++t > 3000) begin
                fail("drain_timeout", $sformatf("%0d/%0d words pending", q[0].size(), q[1].size()));
                q[0].delete();
                q[1].delete();
            end
        end
    endtask

    // Downstream ready: always 1, or 50% random.
    initial begin
        forever begin
            @(posedge aclk); #1;
            m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        beat_t hold [2];
        bit    stall [2];
        beat_t e;
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        forever begin
            @(negedge aclk);
            for (int d = 0; d < 2; d++) begin
                if (areset) begin
                    stall[d] = 1'b0;
                end else begin
                    if (stall[d]) begin
                        chk($sformatf("stall_valid%0d", d), 64'(m_tvalid[d]), 64'd1);
                        chk($sformatf("stall_data%0d", d), m_tdata[d], hold[d].data);
                        chk($sformatf("stall_keep%0d", d), 64'(m_tkeep[d]), 64'(hold[d].keep));
                        chk($sformatf("stall_last%0d", d), 64'(m_tlast[d]), 64'(hold[d].last));
                    end
                    if (m_tvalid[d] && m_tready) begin
                        stall[d] = 1'b0;
                        if (q[d].size() == 0) begin
                            fail($sformatf("unexpected_word%0d", d), $sformatf("%h", m_tdata[d]));
                        end else begin
                            e = q[d].pop_front();
                            chk($sformatf("data%0d", d), m_tdata[d], e.data);
                            chk($sformatf("keep%0d", d), 64'(m_tkeep[d]), 64'(e.keep));
                            chk($sformatf("last%0d", d), 64'(m_tlast[d]), 64'(e.last));
                        end
                    end else if (m_tvalid[d]) begin
                        stall[d]     = 1'b1;
                        hold[d].data = m_tdata[d];
                        hold[d].keep = m_tkeep[d];
                        hold[d].last = m_tlast[d];
                    end else begin
                        stall[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        eth_header_t  e0;
        ipv4_header_t ip0;
        ipv4_header_t ipx;
        vec_t         v;
        bit           ok;

        e0.dst_mac   = 48'hAABBCCDDEEFF;
        e0.src_mac   = 48'h112233445566;
        e0.ethertype = 16'h0800;
        ip0.version        = 4'd4;
        ip0.ihl            = 4'd5;
        ip0.tos            = 8'h00;
        ip0.total_length   = 16'h0073;
        ip0.identification = 16'h0000;
        ip0.flags          = 3'd2;
        ip0.frag_offset    = 13'd0;
        ip0.ttl            = 8'h40;
        ip0.protocol       = 8'h11;
        ip0.checksum       = 16'h1234;
        ip0.src_ip         = 32'hC0A80001;
        ip0.dst_ip         = 32'hC0A800C7;
        eth_hdr  = e0;
        ipv4_hdr = ip0;

        // {eth, ip, payload length, first payload byte, checksum, hdr_err}
        vecs[0] = '{e0, ip0, 1,  8'hAB, 16'hB861, 1'b0};
        vecs[1] = '{e0, ip0, 8,  8'h01, 16'hB861, 1'b0};
        vecs[2] = '{e0, ip0, 20, 8'h10, 16'hB861, 1'b0};
        ipx = ip0; ipx.ihl = 4'd6;
        vecs[3] = '{e0, ipx, 5,  8'h30, 16'hB761, 1'b1};
        ipx = ip0; ipx.ttl = 8'h80; ipx.protocol = 8'h06;
        vecs[4] = '{e0, ipx, 7,  8'h50, 16'h786C, 1'b0};
        vecs[5] = '{e0, ip0, 16, 8'h70, 16'hB861, 1'b0};
        vecs[6] = '{e0, ip0, 14, 8'h90, 16'hB861, 1'b0};

        // Reset state.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_hdr_ready%0d", d), 64'(hdr_ready[d]), 64'd0);
            chk($sformatf("rst_m_tvalid%0d", d), 64'(m_tvalid[d]), 64'd0);
            chk($sformatf("rst_m_tdata%0d", d), m_tdata[d], 64'd0);
            chk($sformatf("rst_m_tkeep%0d", d), 64'(m_tkeep[d]), 64'd0);
            chk($sformatf("rst_m_tlast%0d", d), 64'(m_tlast[d]), 64'd0);
            chk($sformatf("rst_s_tready%0d", d), 64'(s_tready[d]), 64'd0);
            chk($sformatf("rst_hdr_err%0d", d), 64'(hdr_err[d]), 64'd0);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("post_rst_hdr_ready%0d", d), 64'(hdr_ready[d]), 64'd1);

        // Table-driven frames, downstream always ready.
        for (int i = 0; i < 7; i++) send_frame(vecs[i]);
        drain();

        // Random backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v       = vecs[0];
            v.plen  = $urandom_range(1, 30);
            v.pbase = 8'($urandom);
            send_frame(v);
        end
        drain();
        rnd_mode = 1'b0;
        repeat (2) @(posedge aclk);

        // Reset in the middle of the payload.
        v      = vecs[2];
        v.plen = 40;
        build_expect(v);
        send_header(v);
        make_beat(v, 0);
        wait_s_accept(ok);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        areset   = 1'b1;
        @(negedge aclk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("midrst_hdr_ready%0d", d), 64'(hdr_ready[d]), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_m_tvalid%0d", d), 64'(m_tvalid[d]), 64'd0);
            chk($sformatf("midrst_m_tlast%0d", d), 64'(m_tlast[d]), 64'd0);
        end
        q[0].delete();
        q[1].delete();
        @(negedge aclk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("midrst_release_hdr_ready%0d", d), 64'(hdr_ready[d]), 64'd1);

        // Clean frame after the abandoned one.
        send_frame(vecs[2]);
        drain();
        repeat (3) @(posedge aclk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
